// File: rtl/aes_core_sched.sv
// aes_core_sched
//   Round scheduler in front of an iterative AES core shared by two
//   requesters. A round-robin arbiter accepts one job in IDLE, then the
//   scheduler walks the core through rounds 0..Nr (Nr = NR128 or NR256
//   depending on the latched key size), and finally holds the result
//   valid until the owner consumes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/ksel/ready    requester 0 handshake and key size
//   req1_valid/ksel/ready    requester 1 handshake and key size
//   key_gene_en              key-expansion / round-datapath enable
//   Round_Count              current round index to the core
//   first_round, last_round  round-0 / final-round markers during RUN
//   owner, ksel_q            requester and key size of the current job
//   res_valid, res_ready     result handshake towards the owner
//   busy                     high while a job is in RUN or DONE
module aes_core_sched #(
  parameter int NR128 = 10,
  parameter int NR256 = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_ksel,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_ksel,
  output logic       req1_ready,
  output logic       key_gene_en,
  output logic [3:0] Round_Count,
  output logic       first_round,
  output logic       last_round,
  output logic       owner,
  output logic       ksel_q,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [3:0] NR128_IDX = 4'(NR128);
  localparam logic [3:0] NR256_IDX = 4'(NR256);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic       key_gene_en_reg, key_gene_en_next;
  logic [3:0] round_reg, round_next;
  logic       first_reg, first_next;
  logic       last_reg, last_next;
  logic       owner_reg, owner_next;
  logic       ksel_reg, ksel_next;
  logic       res_valid_reg, res_valid_next;
  logic       busy_reg, busy_next;
  // Requester that wins a tie in IDLE; it is the one not served last.
  logic       prio_reg, prio_next;

  logic       grant1;
  logic       grant_any;
  logic       acc_ksel;
  logic [3:0] acc_final;
  logic [3:0] final_idx;
  logic [3:0] round_inc;

  // Arbitration is purely combinational so ready can answer valid in the
  // same cycle; only the IDLE state ever exposes it.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || prio_reg);
    grant_any  = req0_valid || req1_valid;
    req0_ready = (state_reg == IDLE) && req0_valid && !grant1;
    req1_ready = (state_reg == IDLE) && grant1;
    acc_ksel   = grant1 ? req1_ksel : req0_ksel;
    acc_final  = acc_ksel ? NR256_IDX : NR128_IDX;
    final_idx  = ksel_reg ? NR256_IDX : NR128_IDX;
    round_inc  = round_reg + 4'd1;
  end

  always_comb begin
    state_next       = state_reg;
    key_gene_en_next = key_gene_en_reg;
    round_next       = round_reg;
    first_next       = 1'b0;
    last_next        = 1'b0;
    owner_next       = owner_reg;
    ksel_next        = ksel_reg;
    res_valid_next   = res_valid_reg;
    busy_next        = busy_reg;
    prio_next        = prio_reg;

    case (state_reg)
      IDLE: begin
        key_gene_en_next = 1'b0;
        round_next       = 4'd0;
        res_valid_next   = 1'b0;
        busy_next        = 1'b0;
        if (grant_any) begin
          state_next       = RUN;
          key_gene_en_next = 1'b1;
          first_next       = 1'b1;
          last_next        = (acc_final == 4'd0);
          owner_next       = grant1;
          ksel_next        = acc_ksel;
          busy_next        = 1'b1;
        end
      end

      RUN: begin
        // The >= guard keeps the counter from running past the final index
        // even if the last-round marker were ever missed.
        if (last_reg || (round_reg >= final_idx)) begin
          state_next       = DONE;
          key_gene_en_next = 1'b0;
          round_next       = 4'd0;
          res_valid_next   = 1'b1;
        end else begin
          key_gene_en_next = 1'b1;
          round_next       = round_inc;
          last_next        = (round_inc == final_idx);
        end
      end

      DONE: begin
        key_gene_en_next = 1'b0;
        round_next       = 4'd0;
        if (res_ready) begin
          // Returning to IDLE (rather than re-granting here) means the next
          // job is accepted one cycle after the result handshake at best.
          state_next     = IDLE;
          res_valid_next = 1'b0;
          busy_next      = 1'b0;
          prio_next      = ~owner_reg;
        end
      end

      default: begin
        state_next       = IDLE;
        key_gene_en_next = 1'b0;
        round_next       = 4'd0;
        res_valid_next   = 1'b0;
        busy_next        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      key_gene_en_reg <= 1'b0;
      round_reg       <= 4'd0;
      first_reg       <= 1'b0;
      last_reg        <= 1'b0;
      owner_reg       <= 1'b0;
      ksel_reg        <= 1'b0;
      res_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      prio_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      key_gene_en_reg <= key_gene_en_next;
      round_reg       <= round_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      owner_reg       <= owner_next;
      ksel_reg        <= ksel_next;
      res_valid_reg   <= res_valid_next;
      busy_reg        <= busy_next;
      prio_reg        <= prio_next;
    end
  end

  assign key_gene_en = key_gene_en_reg;
  assign Round_Count = round_reg;
  assign first_round = first_reg;
  assign last_round  = last_reg;
  assign owner       = owner_reg;
  assign ksel_q      = ksel_reg;
  assign res_valid   = res_valid_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_aes_core_sched.sv
module tb_aes_core_sched;

  localparam int NR128 = 10;
  localparam int NR256 = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ksel, req0_ready;
  logic       req1_valid, req1_ksel, req1_ready;
  logic       key_gene_en;
  logic [3:0] Round_Count;
  logic       first_round, last_round;
  logic       owner, ksel_q;
  logic       res_valid, res_ready;
  logic       busy;

  aes_core_sched #(.NR128(NR128), .NR256(NR256)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ksel   (req0_ksel),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_ksel   (req1_ksel),
    .req1_ready  (req1_ready),
    .key_gene_en (key_gene_en),
    .Round_Count (Round_Count),
    .first_round (first_round),
    .last_round  (last_round),
    .owner       (owner),
    .ksel_q      (ksel_q),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int fails     = 0;

  // Expected job record pushed at acceptance, popped at result handshake.
  typedef struct {
    logic own;
    logic ks;
    int   done_cyc;
  } exp_t;
  exp_t sb[$];

  // Requester that should win a tie (the one not served last).
  logic model_prio;

  // Observed output vector:
  // {key_gene_en, Round_Count, first, last, owner, ksel_q, res_valid, busy, rdy0, rdy1}
  logic [12:0] obs;
  always_comb obs = {key_gene_en, Round_Count, first_round, last_round, owner,
                     ksel_q, res_valid, busy, req0_ready, req1_ready};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0;
    req0_ksel  = 1'b0;
    req1_valid = 1'b0;
    req1_ksel  = 1'b0;
    res_ready  = 1'b0;
  endtask

  // Runs one complete job from an IDLE cycle: offer, RUN rounds, DONE with
  // an optional stall, result handshake, and the following IDLE cycle.
  // With noise set, request inputs are scrambled during RUN/DONE.
  task automatic do_job(input logic v0, input logic k0, input logic v1,
                        input logic k1, input int stall, input bit noise,
                        input string name);
    exp_t        e, got;
    logic        eg1;
    int          nr, t_acc, first_done;
    logic [12:0] exp_v;
    req0_valid = v0; req0_ksel = k0;
    req1_valid = v1; req1_ksel = k1;
    res_ready  = 1'b0;
    #1;
    eg1   = v1 && (!v0 || model_prio);
    e.own = eg1;
    e.ks  = eg1 ? k1 : k0;
    nr    = e.ks ? NR256 : NR128;
    t_acc = cyc;
    e.done_cyc = t_acc + 2 + nr;
    tests_run++;
    if ({req0_ready, req1_ready} !== {v0 && !eg1, eg1}) begin
      fails++;
      $display("FAIL %s grant: ready=%b expected=%b", name,
               {req0_ready, req1_ready}, {v0 && !eg1, eg1});
    end
    sb.push_back(e);

    for (int r = 0; r <= nr; r++) begin
      step();
      if (noise) begin
        req0_valid = 1'($urandom); req0_ksel = 1'($urandom);
        req1_valid = 1'($urandom); req1_ksel = 1'($urandom);
        #1;
      end
      exp_v = {1'b1, 4'(r), (r == 0), (r == nr), e.own, e.ks, 1'b0, 1'b1, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL %s run round %0d: got=%b expected=%b", name, r, obs, exp_v);
      end
    end

    step();
    first_done = cyc;
    exp_v = {1'b0, 4'd0, 1'b0, 1'b0, e.own, e.ks, 1'b1, 1'b1, 2'b00};
    for (int s = 0; s < stall; s++) begin
      tests_run++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL %s done stall %0d: got=%b expected=%b", name, s, obs, exp_v);
      end
      step();
    end
    res_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s done handshake: got=%b expected=%b", name, obs, exp_v);
    end
    if (res_valid === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      tests_run++;
      if ({owner, ksel_q} !== {got.own, got.ks} || first_done != got.done_cyc) begin
        fails++;
        $display("FAIL %s result: owner/ksel=%b%b cyc=%0d expected=%b%b cyc=%0d",
                 name, owner, ksel_q, first_done, got.own, got.ks, got.done_cyc);
      end
      model_prio = ~got.own;
    end

    step();
    res_ready = 1'b0;
    #1;
    eg1   = req1_valid && (!req0_valid || model_prio);
    exp_v = {1'b0, 4'd0, 1'b0, 1'b0, e.own, e.ks, 1'b0, 1'b0, req0_valid && !eg1, eg1};
    tests_run++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s back to idle: got=%b expected=%b", name, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    model_prio = 1'b0;
    tests_run++;
    if (obs !== 13'd0) begin
      fails++;
      $display("FAIL reset: got=%b expected=%b", obs, 13'd0);
    end
  endtask

  task automatic test_aes128();
    do_job(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "aes128_req0");
    clear_inputs();
  endtask

  task automatic test_aes256();
    do_job(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, "aes256_req1");
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_job(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, $sformatf("b2b_%0d", i));
    end
    clear_inputs();
  endtask

  task automatic test_res_stall();
    do_job(1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, "res_stall");
    clear_inputs();
  endtask

  task automatic test_rst_mid_run();
    exp_t dropped;
    step();
    req1_valid = 1'b1;
    req1_ksel  = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++;
      $display("FAIL rst_mid grant: ready=%b expected=%b", {req0_ready, req1_ready}, 2'b01);
    end
    dropped.own = 1'b1; dropped.ks = 1'b1; dropped.done_cyc = cyc + 2 + NR256;
    sb.push_back(dropped);
    for (int i = 0; i < 7; i++) begin
      step();
      req1_valid = 1'b0;
    end
    tests_run++;
    if (Round_Count !== 4'd6) begin
      fails++;
      $display("FAIL rst_mid round before reset: got=%0d expected=6", Round_Count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    void'(sb.pop_back());
    model_prio = 1'b0;
    tests_run++;
    if (obs !== 13'd0) begin
      fails++;
      $display("FAIL rst_mid after reset: got=%b expected=%b", obs, 13'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid quiet %0d: res_valid=%b busy=%b expected 0 0", i, res_valid, busy);
      end
    end
    do_job(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, "post_reset_prio");
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_prio = 1'b0;
    test_reset();
    test_aes128();
    test_aes256();
    test_back_to_back();
    test_res_stall();
    test_rst_mid_run();
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard leftover: size=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
